// File: rtl/booth_mul_seq_if.sv
// ---------------------------------------------------------------------------
// booth_mul_seq_if
// Handshake and data bundle between the control unit and the sequential
// Booth multiplier.
//   start      request a multiply (sampled on rising clk)
//   is_signed  1 = two's-complement operands, 0 = unsigned (sampled with start)
//   cancel     synchronous abort of an operation in progress
//   op_a       multiplicand, WIDTH bits (sampled with start)
//   op_b       multiplier,   WIDTH bits (sampled with start)
//   busy       high while the multiplier is stepping
//   done       one-cycle pulse when hi/lo hold a new product
//   hi, lo     upper / lower WIDTH bits of the 2*WIDTH-bit product
// master: the requester (control unit / bench); slave: the multiplier.
// ---------------------------------------------------------------------------
interface booth_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             is_signed;
    logic             cancel;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, is_signed, cancel, op_a, op_b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, is_signed, cancel, op_a, op_b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/booth_mul_seq.sv
// ---------------------------------------------------------------------------
// booth_mul_seq
// Multi-cycle radix-4 Booth multiplier, signed or unsigned, with a
// start/done handshake. One Booth step per clock; WIDTH/2+1 steps per
// product. The full 2*WIDTH-bit product is held in hi/lo until the next
// completion or reset.
// Ports:
//   clk   system clock, rising edge
//   clr   asynchronous active-low reset
//   bus   booth_mul_seq_if slave modport (start, is_signed, cancel, op_a,
//         op_b in; busy, done, hi, lo out)
// ---------------------------------------------------------------------------
module booth_mul_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clr,
    booth_mul_seq_if.slave   bus
);
    // Operands are widened by two bits so unsigned values become positive
    // signed numbers and the step count is identical in both modes.
    localparam int EW = WIDTH + 2;
    localparam int N  = WIDTH / 2 + 1;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    state_e                state_q, state_d;
    logic signed [EW:0]    upper_q, upper_d;   // upper accumulator half
    logic [EW-1:0]         mplr_q,  mplr_d;    // lower half, holds remaining multiplier bits
    logic                  bm1_q,   bm1_d;     // b[2i-1] for the current step
    logic signed [EW-1:0]  mcand_q, mcand_d;
    logic [CW-1:0]         cnt_q,   cnt_d;
    logic [WIDTH-1:0]      hi_q,    hi_d;
    logic [WIDTH-1:0]      lo_q,    lo_d;

    logic signed [EW:0]    addend;
    logic signed [EW:0]    sum;
    logic signed [2*EW:0]  shifted;

    function automatic logic [EW-1:0] extend(input logic [WIDTH-1:0] v, input logic s);
        return {{2{s & v[WIDTH-1]}}, v};
    endfunction

    // Booth step datapath: recode three multiplier bits, add, shift by 2.
    // The upper half has one guard bit beyond the operand width, which is
    // enough headroom for +/-2A on top of any partial sum.
    always_comb begin
        addend = '0;
        case ({mplr_q[1:0], bm1_q})
            3'b001, 3'b010: addend = {mcand_q[EW-1], mcand_q};
            3'b011:         addend = {mcand_q, 1'b0};
            3'b100:         addend = -{mcand_q, 1'b0};
            3'b101, 3'b110: addend = -{mcand_q[EW-1], mcand_q};
            default:        addend = '0;
        endcase
        sum     = upper_q + addend;
        shifted = $signed({sum, mplr_q}) >>> 2;
    end

    always_comb begin
        state_d = state_q;
        upper_d = upper_q;
        mplr_d  = mplr_q;
        bm1_d   = bm1_q;
        mcand_d = mcand_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.start && !bus.cancel) begin
                    mcand_d = extend(bus.op_a, bus.is_signed);
                    mplr_d  = extend(bus.op_b, bus.is_signed);
                    upper_d = '0;
                    bm1_d   = 1'b0;
                    cnt_d   = CW'(N);
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.cancel) begin
                    state_d = IDLE;
                end else begin
                    upper_d = shifted[2*EW:EW];
                    mplr_d  = shifted[EW-1:0];
                    bm1_d   = mplr_q[1];
                    cnt_d   = cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        hi_d    = shifted[2*WIDTH-1:WIDTH];
                        lo_d    = shifted[WIDTH-1:0];
                        state_d = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            upper_q <= '0;
            mplr_q  <= '0;
            bm1_q   <= 1'b0;
            mcand_q <= '0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            upper_q <= upper_d;
            mplr_q  <= mplr_d;
            bm1_q   <= bm1_d;
            mcand_q <= mcand_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.done = (state_q == DONE);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_booth_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_booth_mul_seq
// Self-checking bench for booth_mul_seq at WIDTH=32 and WIDTH=8: directed
// cases (latency, signed/unsigned, extreme operands, ignored start,
// back-to-back, cancel, asynchronous reset) followed by randomized
// operations compared against a plain-arithmetic product model.
// ---------------------------------------------------------------------------
module tb_booth_mul_seq;
    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    booth_mul_seq_if #(.WIDTH(32)) if32 ();
    booth_mul_seq_if #(.WIDTH(8))  if8  ();

    booth_mul_seq #(.WIDTH(32)) dut32 (.clk(clk), .clr(clr), .bus(if32.slave));
    booth_mul_seq #(.WIDTH(8))  dut8  (.clk(clk), .clr(clr), .bus(if8.slave));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Exact product of two w-bit operands, low 2*w bits, using 64-bit arithmetic.
    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                            input bit s, input int w);
        logic [63:0] mask, pmask, xa, xb;
        mask  = (w == 32) ? 64'h0000_0000_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        pmask = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
        xa = {32'd0, a} & mask;
        xb = {32'd0, b} & mask;
        if (s && xa[w-1]) xa = xa | ~mask;
        if (s && xb[w-1]) xb = xb | ~mask;
        return (xa * xb) & pmask;
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    function automatic logic [7:0] pick8();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 5))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'h80;
            3:       return 8'h7F;
            default: return r[7:0];
        endcase
    endfunction

    task automatic run32(input logic [31:0] a, input logic [31:0] b, input bit s,
                         output logic [63:0] res, output int lat);
        if32.start = 1'b1; if32.op_a = a; if32.op_b = b; if32.is_signed = s;
        @(posedge clk); #1;
        if32.start = 1'b0;
        lat = 0;
        while (!if32.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        res = {if32.hi, if32.lo};
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit s,
                        output logic [63:0] res, output int lat);
        if8.start = 1'b1; if8.op_a = a; if8.op_b = b; if8.is_signed = s;
        @(posedge clk); #1;
        if8.start = 1'b0;
        lat = 0;
        while (!if8.done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        res = {48'd0, if8.hi, if8.lo};
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] res;
        logic [31:0] a, b;
        logic [7:0]  a8, b8;
        bit          s;
        int          lat, dn;

        clr = 1'b0;
        if32.start = 1'b0; if32.cancel = 1'b0; if32.is_signed = 1'b0;
        if32.op_a = '0; if32.op_b = '0;
        if8.start = 1'b0; if8.cancel = 1'b0; if8.is_signed = 1'b0;
        if8.op_a = '0; if8.op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(if32.busy), 64'd0);
        chk("rst_done", 64'(if32.done), 64'd0);
        chk("rst_hilo", {if32.hi, if32.lo}, 64'd0);
        chk("rst_hilo8", 64'({if8.hi, if8.lo}), 64'd0);
        clr = 1'b1;
        @(posedge clk); #1;

        // Directed products
        run32(32'd6, 32'd7, 1'b0, res, lat);
        chk("u6x7_lat", 64'(lat), 64'd17);
        chk("u6x7", res, 64'h0000_0000_0000_002A);
        run32(32'hFFFF_FFFA, 32'd7, 1'b1, res, lat);
        chk("s_m6x7", res, 64'hFFFF_FFFF_FFFF_FFD6);
        run32(32'hFFFF_FFFA, 32'd7, 1'b0, res, lat);
        chk("u_fffa_x7", res, 64'h0000_0006_FFFF_FFD6);
        run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, res, lat);
        chk("u_max_sq", res, 64'hFFFF_FFFE_0000_0001);
        run32(32'h8000_0000, 32'h8000_0000, 1'b1, res, lat);
        chk("s_min_sq", res, 64'h4000_0000_0000_0000);
        chk("s_min_sq_lat", 64'(lat), 64'd17);

        // start during RUN ignored, then back-to-back from the done cycle
        if32.start = 1'b1; if32.op_a = 32'd2; if32.op_b = 32'd3; if32.is_signed = 1'b0;
        @(posedge clk); #1;                 // E0
        if32.start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        if32.start = 1'b1; if32.op_a = 32'd9; if32.op_b = 32'd9;
        @(posedge clk); #1;                 // E0+5
        if32.start = 1'b0;
        chk("t4_busy", 64'(if32.busy), 64'd1);
        chk("t4_hold", {if32.hi, if32.lo}, 64'h4000_0000_0000_0000);
        lat = 5;
        while (!if32.done && lat < 40) begin @(posedge clk); #1; lat++; end
        chk("t4_lat", 64'(lat), 64'd17);
        chk("t4_2x3", {if32.hi, if32.lo}, 64'd6);
        run32(32'd9, 32'd9, 1'b0, res, lat);
        chk("t4_b2b_lat", 64'(lat + 18), 64'd35);
        chk("t4_9x9", res, 64'h51);

        // cancel mid-operation
        if32.start = 1'b1; if32.op_a = 32'd5; if32.op_b = 32'd5;
        @(posedge clk); #1;                 // E0
        if32.start = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        if32.cancel = 1'b1;
        @(posedge clk); #1;                 // E0+8
        if32.cancel = 1'b0;
        chk("t5_cancel_busy", 64'(if32.busy), 64'd0);
        dn = 0;
        repeat (25) begin @(posedge clk); #1; if (if32.done || if32.busy) dn++; end
        chk("t5_no_done", 64'(dn), 64'd0);
        chk("t5_hold", {if32.hi, if32.lo}, 64'h51);

        // start with cancel in IDLE is rejected
        if32.start = 1'b1; if32.cancel = 1'b1; if32.op_a = 32'd4; if32.op_b = 32'd4;
        @(posedge clk); #1;
        if32.start = 1'b0; if32.cancel = 1'b0;
        dn = 0;
        repeat (20) begin if (if32.done || if32.busy) dn++; @(posedge clk); #1; end
        chk("t5_start_cancel", 64'(dn), 64'd0);

        // asynchronous reset mid-operation
        if32.start = 1'b1; if32.op_a = 32'd3; if32.op_b = 32'd3;
        @(posedge clk); #1;
        if32.start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        clr = 1'b0;
        #1;
        chk("arst_busy", 64'(if32.busy), 64'd0);
        chk("arst_done", 64'(if32.done), 64'd0);
        chk("arst_hilo", {if32.hi, if32.lo}, 64'd0);
        @(posedge clk); #1;
        clr = 1'b1;
        @(posedge clk); #1;
        chk("arst_idle", 64'(if32.busy), 64'd0);

        // randomized WIDTH=32
        for (int i = 0; i < 1000; i++) begin
            a = pick32(); b = pick32(); s = bit'($urandom_range(0, 1));
            run32(a, b, s, res, lat);
            chk("rand32_lat", 64'(lat), 64'd17);
            chk("rand32", res, ref_mul(a, b, s, 32));
        end

        // randomized WIDTH=8
        for (int i = 0; i < 1000; i++) begin
            a8 = pick8(); b8 = pick8(); s = bit'($urandom_range(0, 1));
            run8(a8, b8, s, res, lat);
            chk("rand8_lat", 64'(lat), 64'd5);
            chk("rand8", res, ref_mul({24'd0, a8}, {24'd0, b8}, s, 8));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
